inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ADDR_SIZE, default 32: width of PC and memory address.
REQ-002 Parameter INST_SIZE, default 32: instruction word width.
REQ-003 Ports: clk input 1, the single clock; all state updates on rising edge.
REQ-004 Ports: reset input 1, asynchronous, active-high.
REQ-005 Ports: pc input ADDR_SIZE, current PC from the PC-update stage.
REQ-006 Ports: pcStall output 1, high to hold the PC-update stage.
REQ-007 Ports: flush input 1, high in the cycle the PC is redirected (branch/jump).
REQ-008 Ports: imemReqValid output 1, imemReqReady input 1, imemAddr output ADDR_SIZE: instruction-memory request channel.
REQ-009 Ports: imemRespValid input 1, imemRespData input INST_SIZE: instruction-memory response; it arrives at least 1 cycle after request acceptance, and responses arrive in order.
REQ-010 Ports: decValid output 1, decReady input 1, decInst output INST_SIZE, decPc output ADDR_SIZE: instruction channel to decode.

Function
REQ-011 Request acceptance SHALL be the condition imemReqValid & imemReqReady; at most one request SHALL be outstanding.
REQ-012 imemAddr SHALL equal {pc[ADDR_SIZE-1:2], 2'b00}.
REQ-013 FSM states SHALL be IDLE (none outstanding), WAIT (one outstanding, response to be kept), and DROP (one outstanding, response to be discarded).
REQ-014 occ SHALL be defined as count - pop + (state != IDLE), where count is buffer occupancy (0..2) and pop = decValid & decReady & ~flush.
REQ-015 imemReqValid SHALL be ~reset & ~flush & occ <= 1 & (state==IDLE | (state==WAIT & imemRespValid)).
REQ-016 Back-to-back issue SHALL be supported, so that a request in the response cycle sustains 1 instruction/cycle with a 1-cycle memory.
REQ-017 On acceptance, the pc value SHALL be latched as reqPc, and the next state SHALL be WAIT.
REQ-018 In WAIT with imemRespValid and no flush, {reqPc, imemRespData} SHALL be pushed into the buffer; with no new acceptance, the next state SHALL be IDLE.
REQ-019 In DROP with imemRespValid, the response SHALL be discarded and the next state SHALL be IDLE; no request SHALL be issued in DROP.
REQ-020 imemRespValid in IDLE SHALL be ignored.
REQ-021 flush SHALL clear the buffer (count to 0) with priority over push and pop.
REQ-022 On flush, WAIT without a response that cycle SHALL go to DROP; WAIT with a response that cycle SHALL go to IDLE, with the response discarded.
REQ-023 On flush, DROP SHALL stay DROP unless the response arrives that cycle, in which case it SHALL go to IDLE.
REQ-024 pcStall SHALL be ~flush & ~(imemReqValid & imemReqReady), forced to 1 during reset, so that the PC advances only on acceptance or on redirect.
REQ-025 The buffer SHALL be a 2-entry FIFO with wrap-around pointers.
REQ-026 decValid SHALL equal (count != 0), and decInst/decPc SHALL show the head entry.
REQ-027 Simultaneous push and pop SHALL keep count unchanged.
REQ-028 A push into a full buffer SHALL be impossible by REQ-015; an assertion SHALL flag it.
REQ-029 decInst/decPc SHALL hold their value while decValid & ~decReady.

Reset
REQ-030 On reset assertion, asynchronously: state SHALL be IDLE, count and pointers 0, reqPc 0, and buffer contents 0.
REQ-031 During reset: decValid 0, decInst 0, decPc 0, imemReqValid 0, pcStall 1.
REQ-032 Reset mid-operation SHALL abandon any outstanding request.
REQ-033 A response arriving after reset deassertion SHALL be ignored as in IDLE; the memory is reset by the same reset.

Structure
REQ-034 A shared package/header SHALL hold the ADDR_SIZE/INST_SIZE defaults, the FSM state encodings (IDLE=0, WAIT=1, DROP=2), and the NOP encoding 32'h00000013.
REQ-035 One sub-module, fetch_buffer (2-entry FIFO with push, pop, clear, count, head), SHALL be instantiated; the FSM and handshake logic SHALL live in inst_fetch.

Verification
REQ-036 Stream: reset, pc=0, 1-cycle memory, decReady=1 -> decPc SHALL be 0,4,8,C on consecutive cycles; the first decValid SHALL come 2 cycles after reset release; pcStall SHALL stay 0 in steady state.
REQ-037 Backpressure: decReady=0 for 5 cycles -> count SHALL reach 2, imemReqValid SHALL be 0, pcStall SHALL be 1, and decPc SHALL hold; on release, no instruction SHALL be lost or duplicated.
REQ-038 Flush during WAIT with 3-cycle memory latency and pc redirected to 0x100 -> the stale response SHALL be dropped (DROP then IDLE), and the next decPc SHALL be 0x100.
REQ-039 Flush coincident with a response and with a pop -> the buffer SHALL be empty the next cycle, and neither the response nor the popped entry SHALL appear again.
REQ-040 imemReqReady low for 4 cycles -> pcStall SHALL be 1 and pc SHALL hold; acceptance SHALL occur on the first ready cycle with imemAddr = pc.
REQ-041 Reset asserted in WAIT with 2 entries buffered -> all outputs SHALL immediately take the REQ-031 values, and fetch SHALL restart from pc=0 after release.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// fetch FSM state encodings and the canonical NOP instruction word.
package inst_fetch_pkg;

    localparam int ADDR_SIZE_DEF = 32;
    localparam int INST_SIZE_DEF = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // IDLE: nothing outstanding; WAIT: one outstanding, keep its response;
    // DROP: one outstanding, discard its response (PC was redirected).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {pc, instruction} pairs for decode.
// Clear has priority over push and pop; head is always visible.
module fetch_buffer
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int INST_SIZE = INST_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic [ADDR_SIZE-1:0] push_pc_i,
    input  logic [INST_SIZE-1:0] push_inst_i,
    input  logic                 pop_i,
    input  logic                 clear_i,
    output logic [1:0]           count_o,
    output logic [ADDR_SIZE-1:0] head_pc_o,
    output logic [INST_SIZE-1:0] head_inst_o
);

    logic [ADDR_SIZE-1:0] pc_q   [2];
    logic [INST_SIZE-1:0] inst_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;
    logic                 do_push;
    logic                 do_pop;

    assign do_push = push_i & ~clear_i;
    assign do_pop  = pop_i & ~clear_i & (count_q != 2'd0);

    // Pointer and occupancy bookkeeping; a clear empties the FIFO outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: ;
            endcase
        end
    end

    // Entry storage, written at the tail; contents survive a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q[0]   <= '0;
            pc_q[1]   <= '0;
            inst_q[0] <= '0;
            inst_q[1] <= '0;
        end else if (do_push) begin
            pc_q[wr_ptr_q]   <= push_pc_i;
            inst_q[wr_ptr_q] <= push_inst_i;
        end
    end

    // The issue throttle upstream guarantees room for every push.
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(do_push && count_q == 2'd2));

    assign count_o     = count_q;
    assign head_pc_o   = pc_q[rd_ptr_q];
    assign head_inst_o = inst_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// buffers responses in a 2-entry FIFO for decode and drops stale responses
// after a PC redirect. Back-to-back issue in the response cycle gives
// one instruction per cycle with a single-cycle memory.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int INST_SIZE = INST_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] pc,
    output logic                 pcStall,
    input  logic                 flush,
    output logic                 imemReqValid,
    input  logic                 imemReqReady,
    output logic [ADDR_SIZE-1:0] imemAddr,
    input  logic                 imemRespValid,
    input  logic [INST_SIZE-1:0] imemRespData,
    output logic                 decValid,
    input  logic                 decReady,
    output logic [INST_SIZE-1:0] decInst,
    output logic [ADDR_SIZE-1:0] decPc
);

    fetch_state_e         state_q, state_d;
    logic [ADDR_SIZE-1:0] req_pc_q, req_pc_d;
    logic [1:0]           count;
    logic                 busy;
    logic                 pop;
    logic                 push;
    logic                 accept;
    logic [2:0]           occ;

    assign busy = (state_q != IDLE);
    assign pop  = decValid & decReady & ~flush;
    assign push = (state_q == WAIT) & imemRespValid & ~flush;

    // Slots committed after this cycle: buffered entries left plus the
    // in-flight response. A new request is only allowed if one stays free.
    assign occ = {1'b0, count} - {2'b00, pop} + {2'b00, busy};

    assign imemReqValid = ~reset & ~flush & (occ <= 3'd1)
                        & ((state_q == IDLE) | ((state_q == WAIT) & imemRespValid));
    assign accept   = imemReqValid & imemReqReady;
    assign imemAddr = {pc[ADDR_SIZE-1:2], 2'b00};
    assign pcStall  = reset | (~flush & ~accept);
    assign decValid = (count != 2'd0);

    // Next-state: track whether the single outstanding response is kept.
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        if (accept) req_pc_d = pc;
        case (state_q)
            IDLE: begin
                if (accept) state_d = WAIT;
            end
            WAIT: begin
                if (imemRespValid) state_d = accept ? WAIT : IDLE;
                else if (flush)    state_d = DROP;
            end
            DROP: begin
                if (imemRespValid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request-PC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_buffer #(
        .ADDR_SIZE(ADDR_SIZE),
        .INST_SIZE(INST_SIZE)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_pc_i  (req_pc_q),
        .push_inst_i(imemRespData),
        .pop_i      (pop),
        .clear_i    (flush),
        .count_o    (count),
        .head_pc_o  (decPc),
        .head_inst_o(decInst)
    );

endmodule
